// File: rtl/pwm_reg_pkg.sv
// Register map and sequencer state encoding shared by the PWM soft-start sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pwm_reg_pkg;

    // PWM register file address map
    localparam logic [3:0] REG_CTRL   = 4'h0;  // {mode, en}
    localparam logic [3:0] REG_PERIOD = 4'h4;
    localparam logic [3:0] REG_DUTY1  = 4'h8;
    localparam logic [3:0] REG_DUTY2  = 4'hC;
    localparam logic [3:0] REG_DT_VAL = 4'hD;
    localparam logic [3:0] REG_PSC    = 4'hE;
    localparam logic [3:0] REG_DT_EN  = 4'hF;

    typedef enum logic [3:0] {
        IDLE,
        W_PSC,
        W_PER,
        W_DT,
        W_DTEN,
        W_D1Z,
        W_D2Z,
        W_EN,
        STEP,
        W_D1,
        W_D2,
        WAIT,
        DONE,
        ABORT
    } seq_state_t;

    // States in which the sequencer leaves the register port free for the host.
    function automatic logic host_window(input seq_state_t s);
        return (s == IDLE) || (s == WAIT) || (s == DONE);
    endfunction

endpackage

// File: rtl/pwm_softstart_seq_if.sv
// Host request bus plus register-file port of the PWM soft-start sequencer.
// Latency: n/a (wiring only); master = sequencer side, slave = host/register-file side.
// Backpressure: host_gnt qualifies host_req; the register port itself has none.
interface pwm_softstart_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             host_req;
    logic             host_wr;
    logic [3:0]       host_addr;
    logic [WIDTH-1:0] host_wdata;
    logic             host_gnt;
    logic             host_rvalid;
    logic [WIDTH-1:0] host_rdata;
    logic             reg_wr_en;
    logic             reg_rd_en;
    logic [3:0]       reg_addr;
    logic [WIDTH-1:0] reg_wr_data;
    logic [WIDTH-1:0] reg_rd_data;

    modport master (
        input  host_req, host_wr, host_addr, host_wdata, reg_rd_data,
        output host_gnt, host_rvalid, host_rdata,
               reg_wr_en, reg_rd_en, reg_addr, reg_wr_data
    );

    modport slave (
        output host_req, host_wr, host_addr, host_wdata, reg_rd_data,
        input  host_gnt, host_rvalid, host_rdata,
               reg_wr_en, reg_rd_en, reg_addr, reg_wr_data
    );
endinterface

// File: rtl/pwm_seq_ivl_timer.sv
// Ramp step-interval countdown timer: load, count down while run, flag the last cycle.
// Latency: expire is high in the final run cycle of a loaded interval (load_val cycles after load).
// Backpressure: none; clr has priority over load.
// Ports: clk/rst_n, clr (zero counter), load/load_val, run (count enable), expire.
module pwm_seq_ivl_timer #(
    parameter int IVL_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [IVL_W-1:0] load_val,
    input  logic             run,
    output logic             expire
);
    logic [IVL_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A counter already at zero also expires so WAIT can never stall.
    assign expire = run && (cnt <= IVL_W'(1));

endmodule

// File: rtl/pwm_softstart_seq.sv
// PWM soft-start sequencer: programs psc/period/(deadtime), zeroes duties, enables core, ramps duty1/duty2 to target.
// Latency: a bus op decided in cycle N appears on reg_* in N+1 for one cycle; host read data valid with host_rvalid in N+1.
// Backpressure: sequencer owns the register port; host_gnt only in IDLE/WAIT/DONE with no sequencer op pending.
// Ports: clk, rst_n (async, active-low); start/abort pulses; cfg_* and ramp settings (sampled on start);
//        bus (host request side + register-file side, master modport); busy, done and aborted status.
// Build option: PWM_SEQ_DT_CFG_EN adds cfg_deadtime and the dead-time value/enable writes.
module pwm_softstart_seq
    import pwm_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IVL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   cfg_prescaler,
    input  logic [WIDTH-1:0]   cfg_period,
`ifdef PWM_SEQ_DT_CFG_EN
    input  logic [WIDTH-1:0]   cfg_deadtime,
`endif
    input  logic [WIDTH-1:0]   target_duty,
    input  logic [WIDTH-1:0]   step_size,
    input  logic [IVL_W-1:0]   step_ivl,
    pwm_softstart_seq_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               aborted
);
    seq_state_t       state, state_nxt;
    logic [WIDTH-1:0] psc_q, per_q, tgt_q, step_q, cur;
`ifdef PWM_SEQ_DT_CFG_EN
    logic [WIDTH-1:0] dt_q;
`endif
    logic [IVL_W-1:0] ivl_q;
    logic             start_acc, ivl_load, ivl_expire;
    logic [WIDTH:0]   cur_sum;
    logic [WIDTH-1:0] cur_step;

    // Combinational bus decision and its registered copies
    logic             op_wr, op_rd, gnt, rvalid_nxt, done_nxt, aborted_nxt;
    logic [3:0]       op_addr;
    logic [WIDTH-1:0] op_data;
    logic             wr_en_q, rd_en_q, rvalid_q;
    logic [3:0]       addr_q;
    logic [WIDTH-1:0] wdata_q;

    assign start_acc = (state == IDLE) && start && !abort;

    // One extra bit so the step can never wrap past the target.
    assign cur_sum  = {1'b0, cur} + {1'b0, step_q};
    assign cur_step = (cur_sum >= {1'b0, tgt_q}) ? tgt_q : cur_sum[WIDTH-1:0];

    // Snapshot of configuration; target clipped to period, zero step/interval promoted to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q  <= '0;
            per_q  <= '0;
            tgt_q  <= '0;
            step_q <= '0;
            ivl_q  <= '0;
`ifdef PWM_SEQ_DT_CFG_EN
            dt_q   <= '0;
`endif
        end else if (start_acc) begin
            psc_q  <= cfg_prescaler;
            per_q  <= cfg_period;
            tgt_q  <= (target_duty < cfg_period) ? target_duty : cfg_period;
            step_q <= (step_size == '0) ? WIDTH'(1) : step_size;
            ivl_q  <= (step_ivl == '0) ? IVL_W'(1) : step_ivl;
`ifdef PWM_SEQ_DT_CFG_EN
            dt_q   <= cfg_deadtime;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= '0;
        end else if (start_acc || (state == ABORT)) begin
            cur <= '0;
        end else if (state == STEP) begin
            cur <= cur_step;
        end
    end

    assign ivl_load = (state == W_D2) && (state_nxt == WAIT);

    pwm_seq_ivl_timer #(.IVL_W(IVL_W)) u_ivl_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (state == ABORT),
        .load     (ivl_load),
        .load_val (ivl_q),
        .run      (state == WAIT),
        .expire   (ivl_expire)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (abort && (state != IDLE) && (state != ABORT)) begin
            state_nxt = ABORT;
        end else begin
            case (state)
                IDLE:   if (start_acc) state_nxt = W_PSC;
                W_PSC:  state_nxt = W_PER;
`ifdef PWM_SEQ_DT_CFG_EN
                W_PER:  state_nxt = W_DT;
`else
                W_PER:  state_nxt = W_D1Z;
`endif
                W_DT:   state_nxt = W_DTEN;
                W_DTEN: state_nxt = W_D1Z;
                W_D1Z:  state_nxt = W_D2Z;
                W_D2Z:  state_nxt = W_EN;
                W_EN:   state_nxt = STEP;
                STEP:   state_nxt = W_D1;
                W_D1:   state_nxt = W_D2;
                W_D2:   state_nxt = (cur == tgt_q) ? DONE : WAIT;
                WAIT:   if (ivl_expire) state_nxt = STEP;
                DONE:   state_nxt = IDLE;
                ABORT:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic: sequencer write for this state, else a host op if the port is free.
    always_comb begin
        op_wr       = 1'b0;
        op_rd       = 1'b0;
        op_addr     = '0;
        op_data     = '0;
        gnt         = 1'b0;
        rvalid_nxt  = 1'b0;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        case (state)
            W_PSC:  begin op_wr = 1'b1; op_addr = REG_PSC;    op_data = psc_q;      end
            W_PER:  begin op_wr = 1'b1; op_addr = REG_PERIOD; op_data = per_q;      end
`ifdef PWM_SEQ_DT_CFG_EN
            W_DT:   begin op_wr = 1'b1; op_addr = REG_DT_VAL; op_data = dt_q;       end
            W_DTEN: begin op_wr = 1'b1; op_addr = REG_DT_EN;  op_data = WIDTH'(1);  end
`endif
            W_D1Z:  begin op_wr = 1'b1; op_addr = REG_DUTY1;  op_data = '0;         end
            W_D2Z:  begin op_wr = 1'b1; op_addr = REG_DUTY2;  op_data = '0;         end
            W_EN:   begin op_wr = 1'b1; op_addr = REG_CTRL;   op_data = WIDTH'(1);  end
            W_D1:   begin op_wr = 1'b1; op_addr = REG_DUTY1;  op_data = cur;        end
            W_D2:   begin op_wr = 1'b1; op_addr = REG_DUTY2;  op_data = cur;        end
            ABORT:  begin op_wr = 1'b1; op_addr = REG_CTRL;   op_data = '0; aborted_nxt = 1'b1; end
            DONE:   done_nxt = 1'b1;
            default: ;
        endcase
        if (bus.host_req && host_window(state) && !op_wr) begin
            gnt        = 1'b1;
            op_wr      = bus.host_wr;
            op_rd      = !bus.host_wr;
            op_addr    = bus.host_addr;
            op_data    = bus.host_wr ? bus.host_wdata : '0;
            rvalid_nxt = !bus.host_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            wr_en_q  <= op_wr;
            rd_en_q  <= op_rd;
            addr_q   <= op_addr;
            wdata_q  <= op_data;
            rvalid_q <= rvalid_nxt;
            done     <= done_nxt;
            aborted  <= aborted_nxt;
        end
    end

    assign bus.reg_wr_en   = wr_en_q;
    assign bus.reg_rd_en   = rd_en_q;
    assign bus.reg_addr    = addr_q;
    assign bus.reg_wr_data = wdata_q;
    assign bus.host_rvalid = rvalid_q;
    assign bus.host_rdata  = bus.reg_rd_data;
    assign bus.host_gnt    = gnt;
    assign busy            = (state != IDLE);

endmodule
